// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: access-size codes,
// arbiter FSM states and requester port indices.
package mem_arbiter_pkg;

    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_BYTE = 2'b10;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter; master is the requester,
// slave is the arbiter side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();

    logic              req;
    logic              we;
    logic [1:0]        mask;
    logic              signed_ext;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;
    logic [ADDR_W-1:0] rdata;

    modport master (
        output req, we, mask, signed_ext, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, mask, signed_ext, addr, wdata, lock,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request always wins, on contention the
// port that did not win most recently is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // one-hot winner selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single-cycle RAM. Define MEM_ARB_LOCK_EN
// to honour pN_lock (locked ownership bounded by MAX_HOLD grants).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      p0,
    mem_arbiter_if.slave      p1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_mask,
    output logic              ram_signed_ext,
    output logic [ADDR_W-1:0] ram_wdata,
    input  logic [ADDR_W-1:0] ram_rdata
);

    logic [1:0] req_s;
    logic [1:0] elig_s;
    logic [1:0] gnt_s;
    logic       last_r;     // 1 = port 1 won most recently, so port 0 is favoured
    logic [1:0] rd_tag_r;

    assign req_s = {p1.req, p0.req};

`ifdef MEM_ARB_LOCK_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_r;
    arb_state_e        state_nxt;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt;
    logic [HOLD_W-1:0] hold_inc_s;
    logic              win_lock_s;

    // lock flag of whichever port wins this cycle
    always_comb begin
        win_lock_s = 1'b0;
        if (gnt_s[PORT_CPU]) begin
            win_lock_s = p0.lock;
        end else if (gnt_s[PORT_DMA]) begin
            win_lock_s = p1.lock;
        end else begin
            win_lock_s = 1'b0;
        end
    end

    assign hold_inc_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};

    // ownership FSM next state; the entry grant plus the locked grants in OWNn
    // together may not exceed MAX_HOLD
    always_comb begin
        state_nxt = state_r;
        hold_nxt  = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if ((gnt_s != 2'b00) && win_lock_s && (MAX_HOLD > 1)) begin
                    state_nxt = gnt_s[PORT_DMA] ? ST_OWN1 : ST_OWN0;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (gnt_s == 2'b00) begin
                    state_nxt = state_r;
                end else if (!win_lock_s) begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_inc_s;
                    if (hold_inc_s >= HOLD_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = state_r;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // ownership FSM state and hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt;
            hold_cnt_r <= hold_nxt;
        end
    end

    // while a port owns the RAM the other port's request is masked out
    always_comb begin
        elig_s = 2'b00;
        case (state_r)
            ST_IDLE: elig_s = req_s;
            ST_OWN0: elig_s = req_s & 2'b01;
            ST_OWN1: elig_s = req_s & 2'b10;
            default: elig_s = req_s;
        endcase
    end
`else
    logic unused_lock_s;

    assign unused_lock_s = p0.lock ^ p1.lock;

    // pure round-robin: every request is eligible
    always_comb begin
        elig_s = req_s;
    end
`endif

    rr_pick2 u_pick (
        .req  (elig_s),
        .last (last_r),
        .gnt  (gnt_s)
    );

    assign p0.gnt = gnt_s[PORT_CPU];
    assign p1.gnt = gnt_s[PORT_DMA];

    // winner's fields drive the RAM port, all zero when nobody is granted
    always_comb begin
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_mask       = MASK_WORD;
        ram_signed_ext = 1'b0;
        ram_wdata      = '0;
        if (gnt_s[PORT_CPU]) begin
            ram_we         = p0.we;
            ram_addr       = p0.addr;
            ram_mask       = p0.mask;
            ram_signed_ext = p0.signed_ext;
            ram_wdata      = p0.wdata;
        end else if (gnt_s[PORT_DMA]) begin
            ram_we         = p1.we;
            ram_addr       = p1.addr;
            ram_mask       = p1.mask;
            ram_signed_ext = p1.signed_ext;
            ram_wdata      = p1.wdata;
        end else begin
            ram_we = 1'b0;
        end
    end

    // round-robin pointer moves only on a granted cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (gnt_s != 2'b00) begin
            last_r <= gnt_s[PORT_DMA];
        end else begin
            last_r <= last_r;
        end
    end

    // remember which port has a read in flight so the RAM data returns to it
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag_r <= 2'b00;
        end else begin
            rd_tag_r <= gnt_s & {~p1.we, ~p0.we};
        end
    end

    assign p0.rvalid = rd_tag_r[PORT_CPU];
    assign p1.rvalid = rd_tag_r[PORT_DMA];
    assign p0.rdata  = rd_tag_r[PORT_CPU] ? ram_rdata : '0;
    assign p1.rdata  = rd_tag_r[PORT_DMA] ? ram_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address and data width of both requester ports and the RAM port.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive locked grants to one port before forced release.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pN_req  in  1  (N=0 CPU, N=1 DMA) request valid; held with its fields until pN_gnt.
REQ-006 pN_we / pN_mask / pN_signed_ext  in  1/2/1  write enable, access size (00 word, 01 half, 10 byte), load sign extension.
REQ-007 pN_addr / pN_wdata  in  ADDR_W  byte address, store data.
REQ-008 pN_lock  in  1  keep ownership after this access (read-modify-write); used only with MEM_ARB_LOCK_EN.
REQ-009 pN_gnt  out  1  access accepted this cycle.
REQ-010 pN_rvalid / pN_rdata  out  1/ADDR_W  read data return for that port.
REQ-011 ram_we, ram_addr, ram_mask, ram_signed_ext, ram_wdata  out  1/ADDR_W/2/1/ADDR_W  shared RAM port.
REQ-012 ram_rdata  in  ADDR_W  RAM read data, valid one cycle after address.

Function
REQ-013 Exactly one access is issued per cycle; in cycle T of grant, winner's fields drive ram_* combinationally and pN_gnt=1 for that port only.
REQ-014 With no grant in a cycle, ram_we=0 and ram_addr/ram_wdata/ram_mask/ram_signed_ext=0.
REQ-015 Arbitration is round-robin: when both request, the port not granted most recently wins; a lone requester always wins.
REQ-016 Round-robin pointer updates only on a granted cycle; pointer resets to favour port 0.
REQ-017 Read granted at T: pN_rvalid=1 at T+1 with pN_rdata=ram_rdata; otherwise pN_rvalid=0, pN_rdata=0.
REQ-018 Writes produce no rvalid; write completes at the grant edge.
REQ-019 Back-to-back grants are allowed: grant in T+1 coexists with rvalid for the T read, including a different port.
REQ-020 State machine: IDLE (pointer arbitration), OWN0, OWN1 (locked ownership).
REQ-021 IDLE->OWNn when port n granted with pn_lock=1; OWNn->IDLE when granted access has pn_lock=0, or hold counter reaches MAX_HOLD.
REQ-022 In OWNn only port n may be granted; other port waits with req held, gnt=0.
REQ-023 Hold counter clears on entering OWNn, increments per locked grant, saturates at MAX_HOLD; on forced release the other port wins next if requesting.
REQ-024 In OWNn with pn_req=0, no grant is issued and the state is kept.

Reset
REQ-025 reset in any cycle: state IDLE, pointer to port 0, hold counter 0, pending-read tag cleared; all outputs 0 next cycle.
REQ-026 A read granted in the cycle reset is asserted produces no rvalid.

Configuration
REQ-027 MEM_ARB_LOCK_EN defined: pN_lock honoured, OWN0/OWN1 and hold counter present.
REQ-028 MEM_ARB_LOCK_EN undefined: pN_lock ignored, FSM stays IDLE, pure round-robin; ports unchanged.

Structure
REQ-029 Shared package holds access-size encodings (MASK_WORD/HALF/BYTE), FSM state typedef, port-index constants.
REQ-030 Round-robin pick is a sub-module rr_pick2 (two requests, last-winner in, one-hot grant out); rest is flat.

Verification
REQ-031 Only p0 read addr 0x40 -> p0_gnt at T, ram_addr=0x40, p0_rvalid at T+1 with ram_rdata 0x12345678.
REQ-032 Both request every cycle, 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1.
REQ-033 p1 write 0x8 data 0xDEADBEEF, mask 00 -> ram_we=1 one cycle, no p1_rvalid.
REQ-034 LOCK_EN: p0 lock=1 for 3 reads, then lock=0, p1 requesting -> 4 consecutive p0 grants, then p1.
REQ-035 LOCK_EN, MAX_HOLD=8, p0 lock held high -> 8 p0 grants then p1 granted.
REQ-036 reset asserted in cycle of p1 read grant -> no p1_rvalid, all outputs 0, next grant favours p0.
